// File: rtl/chess_clock_pkg.sv
// Shared definitions for the chess clock: game state encoding, winner codes,
// default prescaler sizing and a small helper picking the opponent of the
// player currently on move.
package chess_clock_pkg;

  localparam int TICKS_PER_SEC_DEFAULT = 100000000;
  localparam int TICK_W_DEFAULT        = 27;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN_P1 = 2'd1,
    ST_RUN_P2 = 2'd2,
    ST_OVER   = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    WIN_NONE = 2'b00,
    WIN_P1   = 2'b01,
    WIN_P2   = 2'b10,
    WIN_DRAW = 2'b11
  } winner_t;

  // Winner when the player on move loses (resign or timeout).
  function automatic winner_t opponent_wins(input state_t s);
    return (s == ST_RUN_P1) ? WIN_P2 : WIN_P1;
  endfunction

endpackage

// File: rtl/chess_tick_gen.sv
// One-second prescaler.
//   clk, reset : clock, synchronous active-high reset (count -> 0)
//   clr        : force count to 0 (wins over en)
//   en         : advance count by one per cycle
//   wrap       : high while enabled and count sits at TICKS_PER_SEC-1, i.e. the
//                cycle on which the count rolls back to 0
module chess_tick_gen #(
  parameter int TICKS_PER_SEC = 10,
  parameter int TICK_W        = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic wrap
);

  localparam logic [TICK_W-1:0] LAST = TICK_W'(TICKS_PER_SEC - 1);

  logic [TICK_W-1:0] cnt_q, cnt_d;

  assign wrap = en && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + TICK_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/chess_turn_ctrl.sv
// Game-sequencing controller for the two-player chess clock.
// Owns the game FSM, push-button edge detection and the one-second prescaler;
// emits load/dec/inc strobes to the two countdown timers and drives the LEDs.
//   Inputs : clk, reset (sync, active-high), start, switch_turn,
//            surrender_player1/2 (levels), p1_zero/p2_zero (timer at 00:00)
//   Outputs: timer_load (level), p1/p2_dec and p1/p2_inc (1-cycle pulses),
//            green/red LEDs per player, game_over, winner[1:0]
// Every output is a flop; next values are derived from the next state so the
// outputs change on the same edge where the deciding input edge is seen.
module chess_turn_ctrl
  import chess_clock_pkg::*;
#(
  parameter int TICKS_PER_SEC = TICKS_PER_SEC_DEFAULT,
  parameter int TICK_W        = TICK_W_DEFAULT,
  parameter int INC_EN        = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       switch_turn,
  input  logic       surrender_player1,
  input  logic       surrender_player2,
  input  logic       p1_zero,
  input  logic       p2_zero,
  output logic       timer_load,
  output logic       p1_dec,
  output logic       p2_dec,
  output logic       p1_inc,
  output logic       p2_inc,
  output logic       player1_green_led,
  output logic       player2_green_led,
  output logic       player1_red_led,
  output logic       player2_red_led,
  output logic       game_over,
  output logic [1:0] winner
);

  state_t  state_q, state_d;
  winner_t winner_q, winner_d;
  logic    start_q, switch_q;
  logic    timer_load_q, timer_load_d;
  logic    p1_dec_q, p1_dec_d, p2_dec_q, p2_dec_d;
  logic    p1_inc_q, p1_inc_d, p2_inc_q, p2_inc_d;
  logic    green1_q, green1_d, green2_q, green2_d;
  logic    red1_q, red1_d, red2_q, red2_d;
  logic    over_q, over_d;

  logic    start_rise, switch_rise, active_zero;
  logic    tick_clr, tick_en, tick_wrap;

  chess_tick_gen #(
    .TICKS_PER_SEC(TICKS_PER_SEC),
    .TICK_W       (TICK_W)
  ) u_tick_gen (
    .clk  (clk),
    .reset(reset),
    .clr  (tick_clr),
    .en   (tick_en),
    .wrap (tick_wrap)
  );

  always_comb begin
    start_rise  = start & ~start_q;
    switch_rise = switch_turn & ~switch_q;
    active_zero = 1'b0;
    state_d     = state_q;
    winner_d    = winner_q;
    p1_dec_d    = 1'b0;
    p2_dec_d    = 1'b0;
    p1_inc_d    = 1'b0;
    p2_inc_d    = 1'b0;
    // Prescaler only runs while a player is on move; any turn boundary restarts it.
    tick_clr    = 1'b1;
    tick_en     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        winner_d = WIN_NONE;
        if (start_rise) state_d = ST_RUN_P1;
      end
      ST_RUN_P1, ST_RUN_P2: begin
        // Only the player on move can time out.
        active_zero = (state_q == ST_RUN_P1) ? p1_zero : p2_zero;
        tick_clr    = 1'b0;
        tick_en     = 1'b1;
        if (surrender_player1 && surrender_player2) begin
          state_d  = ST_OVER;
          winner_d = WIN_DRAW;
          tick_clr = 1'b1;
        end else if (surrender_player1) begin
          state_d  = ST_OVER;
          winner_d = WIN_P2;
          tick_clr = 1'b1;
        end else if (surrender_player2) begin
          state_d  = ST_OVER;
          winner_d = WIN_P1;
          tick_clr = 1'b1;
        end else if (active_zero) begin
          state_d  = ST_OVER;
          winner_d = opponent_wins(state_q);
          tick_clr = 1'b1;
        end else if (switch_rise) begin
          // The partial second of the finished move is discarded.
          state_d  = (state_q == ST_RUN_P1) ? ST_RUN_P2 : ST_RUN_P1;
          tick_clr = 1'b1;
          if (INC_EN != 0) begin
            p1_inc_d = (state_q == ST_RUN_P1);
            p2_inc_d = (state_q == ST_RUN_P2);
          end
        end else if (tick_wrap) begin
          p1_dec_d = (state_q == ST_RUN_P1);
          p2_dec_d = (state_q == ST_RUN_P2);
        end
      end
      default: ; // ST_OVER: latched until reset
    endcase

    timer_load_d = (state_d == ST_IDLE);
    green1_d     = (state_d == ST_RUN_P1);
    green2_d     = (state_d == ST_RUN_P2);
    over_d       = (state_d == ST_OVER);
    red1_d       = over_d && ((winner_d == WIN_P2) || (winner_d == WIN_DRAW));
    red2_d       = over_d && ((winner_d == WIN_P1) || (winner_d == WIN_DRAW));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      winner_q     <= WIN_NONE;
      start_q      <= 1'b0;
      switch_q     <= 1'b0;
      timer_load_q <= 1'b1;
      p1_dec_q     <= 1'b0;
      p2_dec_q     <= 1'b0;
      p1_inc_q     <= 1'b0;
      p2_inc_q     <= 1'b0;
      green1_q     <= 1'b0;
      green2_q     <= 1'b0;
      red1_q       <= 1'b0;
      red2_q       <= 1'b0;
      over_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      winner_q     <= winner_d;
      start_q      <= start;
      switch_q     <= switch_turn;
      timer_load_q <= timer_load_d;
      p1_dec_q     <= p1_dec_d;
      p2_dec_q     <= p2_dec_d;
      p1_inc_q     <= p1_inc_d;
      p2_inc_q     <= p2_inc_d;
      green1_q     <= green1_d;
      green2_q     <= green2_d;
      red1_q       <= red1_d;
      red2_q       <= red2_d;
      over_q       <= over_d;
    end
  end

  assign timer_load        = timer_load_q;
  assign p1_dec            = p1_dec_q;
  assign p2_dec            = p2_dec_q;
  assign p1_inc            = p1_inc_q;
  assign p2_inc            = p2_inc_q;
  assign player1_green_led = green1_q;
  assign player2_green_led = green2_q;
  assign player1_red_led   = red1_q;
  assign player2_red_led   = red2_q;
  assign game_over         = over_q;
  assign winner            = winner_q;

endmodule

// File: tb/tb_chess_turn_ctrl.sv
// Bench for chess_turn_ctrl: two instances (increment on / off) share stimulus;
// a cycle-level game model predicts every output after each clock edge.
module tb_chess_turn_ctrl;

  localparam int N = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, start, switch_turn, s1, s2, p1z, p2z;

  logic a_tl, a_p1d, a_p2d, a_p1i, a_p2i, a_g1, a_g2, a_r1, a_r2, a_go;
  logic b_tl, b_p1d, b_p2d, b_p1i, b_p2i, b_g1, b_g2, b_r1, b_r2, b_go;
  logic [1:0] a_win, b_win;
  logic [11:0] a_vec, b_vec;

  assign a_vec = {a_tl, a_p1d, a_p2d, a_p1i, a_p2i, a_g1, a_g2, a_r1, a_r2, a_go, a_win};
  assign b_vec = {b_tl, b_p1d, b_p2d, b_p1i, b_p2i, b_g1, b_g2, b_r1, b_r2, b_go, b_win};

  chess_turn_ctrl #(.TICKS_PER_SEC(N), .TICK_W(4), .INC_EN(1)) dut_inc (
    .clk(clk), .reset(reset), .start(start), .switch_turn(switch_turn),
    .surrender_player1(s1), .surrender_player2(s2), .p1_zero(p1z), .p2_zero(p2z),
    .timer_load(a_tl), .p1_dec(a_p1d), .p2_dec(a_p2d), .p1_inc(a_p1i), .p2_inc(a_p2i),
    .player1_green_led(a_g1), .player2_green_led(a_g2),
    .player1_red_led(a_r1), .player2_red_led(a_r2),
    .game_over(a_go), .winner(a_win)
  );

  chess_turn_ctrl #(.TICKS_PER_SEC(N), .TICK_W(4), .INC_EN(0)) dut_noinc (
    .clk(clk), .reset(reset), .start(start), .switch_turn(switch_turn),
    .surrender_player1(s1), .surrender_player2(s2), .p1_zero(p1z), .p2_zero(p2z),
    .timer_load(b_tl), .p1_dec(b_p1d), .p2_dec(b_p2d), .p1_inc(b_p1i), .p2_inc(b_p2i),
    .player1_green_led(b_g1), .player2_green_led(b_g2),
    .player1_red_led(b_r1), .player2_red_led(b_r2),
    .game_over(b_go), .winner(b_win)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s @cycle %0d: got 0x%0h expected 0x%0h", tag, cyc, got, exp);
    end
  endtask

  // ---------------- reference game model ----------------
  bit m_running, m_over, m_prev_start, m_prev_sw;
  int m_player, m_elapsed, m_winner;
  bit e_dec1, e_dec2, e_inc1, e_inc2;

  task automatic m_finish(input int w);
    m_running = 0;
    m_over    = 1;
    m_winner  = w;
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_update();
    bit sr, wr, zero;
    e_dec1 = 0; e_dec2 = 0; e_inc1 = 0; e_inc2 = 0;
    if (reset) begin
      m_running = 0; m_over = 0; m_winner = 0; m_elapsed = 0;
      m_prev_start = 0; m_prev_sw = 0; m_player = 1;
      return;
    end
    sr = start && !m_prev_start;
    wr = switch_turn && !m_prev_sw;
    m_prev_start = start;
    m_prev_sw    = switch_turn;
    if (m_over) begin
      // game finished: nothing moves
    end else if (m_running) begin
      zero = (m_player == 1) ? p1z : p2z;
      if (s1 && s2)   m_finish(3);
      else if (s1)    m_finish(2);
      else if (s2)    m_finish(1);
      else if (zero)  m_finish(3 - m_player);
      else if (wr) begin
        if (m_player == 1) e_inc1 = 1; else e_inc2 = 1;
        m_player  = 3 - m_player;
        m_elapsed = 0;
      end else begin
        m_elapsed++;
        if (m_elapsed == N) begin
          if (m_player == 1) e_dec1 = 1; else e_dec2 = 1;
          m_elapsed = 0;
        end
      end
    end else if (sr) begin
      m_running = 1;
      m_player  = 1;
      m_elapsed = 0;
    end
  endtask

  function automatic logic [11:0] exp_vec(input bit with_inc);
    bit r1, r2;
    r1 = m_over && (m_winner == 2 || m_winner == 3);
    r2 = m_over && (m_winner == 1 || m_winner == 3);
    return {!m_running && !m_over, e_dec1, e_dec2, with_inc & e_inc1, with_inc & e_inc2,
            m_running && m_player == 1, m_running && m_player == 2, r1, r2, m_over,
            2'(m_winner)};
  endfunction

  task automatic step();
    model_update();
    @(posedge clk);
    #1;
    cyc++;
    check_eq("outs_inc_on", a_vec, exp_vec(1'b1));
    check_eq("outs_inc_off", b_vec, exp_vec(1'b0));
    check_eq("strobe_onehot", 32'($countones({a_p1d, a_p2d, a_p1i, a_p2i}) <= 1), 32'd1);
  endtask

  task automatic do_reset();
    reset = 1; start = 0; switch_turn = 0; s1 = 0; s2 = 0; p1z = 0; p2z = 0;
    step();
    step();
    reset = 0;
  endtask

  int pulses[$];
  int cnt_a, cnt_b, wait_cnt;

  initial begin
    // 1: idle after reset
    $display("[TB] scenario idle");
    do_reset();
    cnt_a = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      cnt_a += int'(a_p1d) + int'(a_p2d);
    end
    check_eq("idle_no_dec", 32'(cnt_a), 32'd0);
    check_eq("idle_timer_load", 32'(a_tl), 32'd1);

    // 2: player 1 runs for 35 cycles
    $display("[TB] scenario p1_run");
    start = 1;
    step();
    check_eq("p1_green", 32'(a_g1), 32'd1);
    cnt_b = 0;
    for (int i = 0; i < 35; i++) begin
      step();
      if (a_p1d) pulses.push_back(cyc);
      cnt_b += int'(a_p2d);
    end
    check_eq("p1_dec_count", 32'(pulses.size()), 32'd3);
    check_eq("p2_dec_none", 32'(cnt_b), 32'd0);
    if (pulses.size() >= 3) begin
      check_eq("p1_dec_gap0", 32'(pulses[1] - pulses[0]), 32'(N));
      check_eq("p1_dec_gap1", 32'(pulses[2] - pulses[1]), 32'(N));
    end

    // 3: switch after 7 prescaler counts
    $display("[TB] scenario switch");
    do_reset();
    start = 1;
    step();
    for (int i = 0; i < 7; i++) step();
    switch_turn = 1;
    step();
    check_eq("switch_p1_inc", 32'(a_p1i), 32'd1);
    check_eq("switch_p1_inc_off", 32'(b_p1i), 32'd0);
    check_eq("switch_p2_green", 32'(a_g2), 32'd1);
    wait_cnt = 0;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (a_p2d) begin
        wait_cnt = k;
        break;
      end
    end
    check_eq("first_p2_dec_delay", 32'(wait_cnt), 32'(N));

    // 4: player 2 times out
    $display("[TB] scenario p2_timeout");
    switch_turn = 0;
    p2z = 1;
    step();
    check_eq("timeout_winner", 32'(a_win), 32'd1);
    check_eq("timeout_red2", 32'(a_r2), 32'd1);
    p2z = 0;
    for (int i = 0; i < 6; i++) begin
      start = i[0];
      switch_turn = ~i[0];
      step();
    end
    check_eq("over_held_winner", 32'(a_win), 32'd1);
    check_eq("over_held_flag", 32'(a_go), 32'd1);

    // 5: surrender beats switch
    $display("[TB] scenario surrender_p1");
    do_reset();
    start = 1;
    step();
    step();
    s1 = 1;
    switch_turn = 1;
    step();
    check_eq("surrender_p1_winner", 32'(a_win), 32'd2);
    check_eq("surrender_no_inc", 32'(a_p1i), 32'd0);

    // 6: double surrender
    $display("[TB] scenario draw");
    do_reset();
    start = 1;
    step();
    s1 = 1;
    s2 = 1;
    step();
    check_eq("draw_winner", 32'(a_win), 32'd3);
    check_eq("draw_reds", 32'({a_r1, a_r2}), 32'd3);

    // 7: reset mid RUN_P2, then restart
    $display("[TB] scenario reset_midgame");
    do_reset();
    start = 1;
    step();
    switch_turn = 1;
    step();
    for (int i = 0; i < 4; i++) step();
    reset = 1;
    step();
    check_eq("midreset_load", 32'(a_tl), 32'd1);
    check_eq("midreset_winner", 32'(a_win), 32'd0);
    reset = 0;
    start = 0;
    switch_turn = 0;
    step();
    start = 1;
    step();
    check_eq("restart_p1_green", 32'(a_g1), 32'd1);

    // 8: random play
    $display("[TB] scenario random");
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 199) == 0) || (m_over && $urandom_range(0, 14) == 0);
      if ($urandom_range(0, 7) == 0) start = ~start;
      if ($urandom_range(0, 5) == 0) switch_turn = ~switch_turn;
      s1  = ($urandom_range(0, 149) == 0);
      s2  = ($urandom_range(0, 149) == 0);
      p1z = ($urandom_range(0, 59) == 0);
      p2z = ($urandom_range(0, 59) == 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
